// File: rtl/pingpong_iq_buffer.sv
// Two-bank ping-pong buffer for packed multi-channel I/Q blocks of variable length.
// The writer fills one bank while the reader drains the other; each bank records its block length.
module pingpong_iq_buffer #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 1,
  parameter int DEPTH      = 1200,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data_q,
  input  logic                         wr_last,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data_q,
  output logic                         rd_last,
  output logic [ADDR_W:0]              rd_len,
  output logic [1:0]                   bank_full,
  output logic                         overflow
);

  localparam int LANE_W  = NUM_CH * DATA_WIDTH;
  localparam int ENTRY_W = 2 * LANE_W;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  // Writer state
  logic                 wr_bank_q,   wr_bank_d;
  logic [ADDR_W-1:0]    wr_addr_q,   wr_addr_d;
  logic [1:0]           bank_full_q, bank_full_d;
  logic [1:0][ADDR_W:0] bank_len_q,  bank_len_d;
  logic                 overflow_q,  overflow_d;

  // Reader state; rd_idx_q is the index of the entry currently held in the output register
  rd_state_e            rd_state_q,  rd_state_d;
  logic                 rd_bank_q,   rd_bank_d;
  logic [ADDR_W-1:0]    rd_idx_q,    rd_idx_d;
  logic [ADDR_W:0]      rd_len_q,    rd_len_d;
  logic                 rd_valid_q,  rd_valid_d;

  logic                 wr_en;
  logic                 wr_close;
  logic                 rd_other;
  logic                 last_entry;
  logic                 rd_free;
  logic                 fetch;
  logic                 fetch_bank;
  logic [ADDR_W-1:0]    fetch_addr;

  logic [ENTRY_W-1:0]   mem [2][DEPTH];
  logic [ENTRY_W-1:0]   out_entry_q;

  // The writer only ever sees registered bank_full, so a bank freed this cycle opens next cycle.
  assign wr_ready   = !bank_full_q[wr_bank_q] && !reset;
  assign wr_en      = wr_valid && wr_ready;
  assign wr_close   = wr_en && (wr_last || (wr_addr_q == ADDR_LAST));
  assign rd_other   = ~rd_bank_q;
  assign last_entry = ({1'b0, rd_idx_q} == (rd_len_q - LEN_ONE));

  // NOTE: every always_comb output is given its default first, so no path can infer a latch.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    bank_full_d = bank_full_q;
    bank_len_d  = bank_len_q;
    overflow_d  = overflow_q;

    if (wr_en) begin
      if (wr_close) begin
        bank_full_d[wr_bank_q] = 1'b1;
        bank_len_d[wr_bank_q]  = {1'b0, wr_addr_q} + LEN_ONE;
        wr_bank_d              = ~wr_bank_q;
        wr_addr_d              = '0;
        if (!wr_last) begin
          overflow_d = 1'b1;
        end
      end else begin
        wr_addr_d = wr_addr_q + ADDR_ONE;
      end
    end

    // Writer only closes a non-full bank and the reader only frees a full one, so they never collide.
    if (rd_free) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end

    if (flush) begin
      wr_bank_d   = 1'b0;
      wr_addr_d   = '0;
      bank_full_d = '0;
      bank_len_d  = '0;
      overflow_d  = overflow_q;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    rd_idx_d   = rd_idx_q;
    rd_len_d   = rd_len_q;
    rd_valid_d = rd_valid_q;
    fetch      = 1'b0;
    fetch_bank = rd_bank_q;
    fetch_addr = '0;
    rd_free    = 1'b0;

    case (rd_state_q)
      RD_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          fetch      = 1'b1;
          rd_len_d   = bank_len_q[rd_bank_q];
          rd_idx_d   = '0;
          rd_valid_d = 1'b1;
          rd_state_d = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (rd_valid_q && rd_ready) begin
          if (last_entry) begin
            rd_free   = 1'b1;
            rd_bank_d = rd_other;
            // Chain straight into the other bank when it is already waiting.
            if (bank_full_q[rd_other]) begin
              fetch      = 1'b1;
              fetch_bank = rd_other;
              rd_len_d   = bank_len_q[rd_other];
              rd_idx_d   = '0;
            end else begin
              rd_valid_d = 1'b0;
              rd_state_d = RD_IDLE;
            end
          end else begin
            fetch      = 1'b1;
            fetch_addr = rd_idx_q + ADDR_ONE;
            rd_idx_d   = rd_idx_q + ADDR_ONE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    if (flush) begin
      rd_state_d = RD_IDLE;
      rd_bank_d  = 1'b0;
      rd_idx_d   = '0;
      rd_len_d   = '0;
      rd_valid_d = 1'b0;
      fetch      = 1'b0;
      rd_free    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= '0;
      bank_full_q <= '0;
      bank_len_q  <= '0;
      overflow_q  <= 1'b0;
      rd_state_q  <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      rd_len_q    <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      bank_full_q <= bank_full_d;
      bank_len_q  <= bank_len_d;
      overflow_q  <= overflow_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      rd_len_q    <= rd_len_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and bank_full alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank_q][wr_addr_q] <= {wr_data_q, wr_data_i};
    end
  end

  // Synchronous read straight into the output register, so a stalled entry simply holds.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_entry_q <= '0;
    end else if (fetch) begin
      out_entry_q <= mem[fetch_bank][fetch_addr];
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_valid_q && last_entry;
  assign rd_len    = rd_len_q;
  assign rd_data_i = out_entry_q[LANE_W-1:0];
  assign rd_data_q = out_entry_q[ENTRY_W-1:LANE_W];
  assign bank_full = bank_full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pingpong_iq_buffer.sv
// Scoreboard bench for pingpong_iq_buffer: a 1-channel and a 2-channel instance (DEPTH=8)
// share one stimulus stream; every output sample is popped from a queue filled at write time.
module tb_pingpong_iq_buffer;

  localparam int DW    = 18;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = 2 * DW;

  typedef struct {
    logic [LW-1:0] di;
    logic [LW-1:0] dq;
    logic          last;
    logic [AW:0]   len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, wr_valid, wr_last, rd_ready;
  logic [LW-1:0] wr_data_i, wr_data_q;

  logic          a_wr_ready, a_rd_valid, a_rd_last, a_overflow;
  logic [DW-1:0] a_rd_data_i, a_rd_data_q;
  logic [AW:0]   a_rd_len;
  logic [1:0]    a_bank_full;

  logic          b_wr_ready, b_rd_valid, b_rd_last, b_overflow;
  logic [LW-1:0] b_rd_data_i, b_rd_data_q;
  logic [AW:0]   b_rd_len;
  logic [1:0]    b_bank_full;

  pingpong_iq_buffer #(.DATA_WIDTH(DW), .NUM_CH(1), .DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(a_wr_ready),
    .wr_data_i(wr_data_i[DW-1:0]), .wr_data_q(wr_data_q[DW-1:0]), .wr_last(wr_last),
    .rd_valid(a_rd_valid), .rd_ready(rd_ready),
    .rd_data_i(a_rd_data_i), .rd_data_q(a_rd_data_q), .rd_last(a_rd_last),
    .rd_len(a_rd_len), .bank_full(a_bank_full), .overflow(a_overflow)
  );

  pingpong_iq_buffer #(.DATA_WIDTH(DW), .NUM_CH(2), .DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .wr_data_i(wr_data_i), .wr_data_q(wr_data_q), .wr_last(wr_last),
    .rd_valid(b_rd_valid), .rd_ready(rd_ready),
    .rd_data_i(b_rd_data_i), .rd_data_q(b_rd_data_q), .rd_last(b_rd_last),
    .rd_len(b_rd_len), .bank_full(b_bank_full), .overflow(b_overflow)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t blk[$];

  bit            last_acc;
  int            blocks_out;
  bit            chk_gap, after_last;
  int            idle;
  bit            prev_stall;
  logic [LW-1:0] hold_i, hold_q;
  logic          hold_last;
  logic [AW:0]   hold_len;

  function automatic logic [LW-1:0] pack2(input int c0, input int c1);
    logic [DW-1:0] l0, l1;
    l0 = DW'(c0);
    l1 = DW'(c1);
    return {l1, l0};
  endfunction

  // Called just after a falling edge with inputs set; checks, then advances one clock.
  task automatic step();
    exp_t e;
    exp_t ea;
    int   n;
    #1;
    if (prev_stall) begin
      total++;
      if (b_rd_valid !== 1'b1 || b_rd_data_i !== hold_i || b_rd_data_q !== hold_q ||
          b_rd_last !== hold_last || b_rd_len !== hold_len) begin
        bad++;
        $display("FAIL stall_hold: got v=%b i=%h q=%h last=%b len=%0d want v=1 i=%h q=%h last=%b len=%0d",
                 b_rd_valid, b_rd_data_i, b_rd_data_q, b_rd_last, b_rd_len,
                 hold_i, hold_q, hold_last, hold_len);
      end
    end

    if (b_rd_valid && rd_ready) begin
      total++;
      if (chk_gap && after_last && idle > 1) begin
        bad++;
        $display("FAIL bubble: got %0d idle cycles between blocks want <=1", idle);
      end
      after_last = (b_rd_last === 1'b1);
      idle       = 0;
      if (b_rd_last === 1'b1) blocks_out++;
      total++;
      if (sb_b.size() == 0) begin
        bad++;
        $display("FAIL b_extra: got i=%h q=%h with no sample expected", b_rd_data_i, b_rd_data_q);
      end else begin
        e = sb_b.pop_front();
        if (b_rd_data_i !== e.di || b_rd_data_q !== e.dq || b_rd_last !== e.last || b_rd_len !== e.len) begin
          bad++;
          $display("FAIL b_sample: got i=%h q=%h last=%b len=%0d want i=%h q=%h last=%b len=%0d",
                   b_rd_data_i, b_rd_data_q, b_rd_last, b_rd_len, e.di, e.dq, e.last, e.len);
        end
      end
    end else if (rd_ready && after_last) begin
      idle++;
    end

    if (a_rd_valid && rd_ready) begin
      total++;
      if (sb_a.size() == 0) begin
        bad++;
        $display("FAIL a_extra: got i=%h q=%h with no sample expected", a_rd_data_i, a_rd_data_q);
      end else begin
        ea = sb_a.pop_front();
        if (a_rd_data_i !== ea.di[DW-1:0] || a_rd_data_q !== ea.dq[DW-1:0] ||
            a_rd_last !== ea.last || a_rd_len !== ea.len) begin
          bad++;
          $display("FAIL a_sample: got i=%h q=%h last=%b len=%0d want i=%h q=%h last=%b len=%0d",
                   a_rd_data_i, a_rd_data_q, a_rd_last, a_rd_len,
                   ea.di[DW-1:0], ea.dq[DW-1:0], ea.last, ea.len);
        end
      end
    end

    prev_stall = b_rd_valid && !rd_ready && !reset && !flush;
    hold_i     = b_rd_data_i;
    hold_q     = b_rd_data_q;
    hold_last  = b_rd_last;
    hold_len   = b_rd_len;

    last_acc = 1'b0;
    if (reset || flush) begin
      blk.delete();
      sb_a.delete();
      sb_b.delete();
    end else if (wr_valid && b_wr_ready) begin
      last_acc = 1'b1;
      e.di   = wr_data_i;
      e.dq   = wr_data_q;
      e.last = 1'b0;
      e.len  = '0;
      blk.push_back(e);
      if (wr_last || blk.size() == DEPTH) begin
        n = blk.size();
        for (int k = 0; k < n; k++) begin
          e      = blk[k];
          e.len  = (AW + 1)'(n);
          e.last = (k == n - 1);
          sb_a.push_back(e);
          sb_b.push_back(e);
        end
        blk.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic write_sample(input logic [LW-1:0] di, input logic [LW-1:0] dq, input logic last);
    wr_valid  = 1'b1;
    wr_data_i = di;
    wr_data_q = dq;
    wr_last   = last;
    for (int n = 0; n < 100; n++) begin
      step();
      if (last_acc) break;
    end
    total++;
    if (!last_acc) begin
      bad++;
      $display("FAIL write_timeout: got wr_ready=0 for 100 cycles want acceptance");
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic write_block(input int n, input int base, input bit close_last);
    for (int k = 0; k < n; k++) begin
      write_sample(pack2(base + k, base + k + 1000), pack2(-(base + k), -(base + k + 1000)),
                   close_last && (k == n - 1));
    end
  endtask

  task automatic drain(input bit toggle);
    rd_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (sb_b.size() == 0 && sb_a.size() == 0 && !b_rd_valid && !a_rd_valid) break;
      if (toggle) rd_ready = ~rd_ready;
      step();
    end
    total++;
    if (sb_b.size() != 0 || sb_a.size() != 0) begin
      bad++;
      $display("FAIL drain_left: got %0d/%0d samples undelivered want 0", sb_a.size(), sb_b.size());
    end
    rd_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    #1;
    total++;
    if (b_wr_ready !== 1'b0 || a_wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL wr_ready_in_reset: got a=%b b=%b want 0", a_wr_ready, b_wr_ready);
    end
    reset = 1'b0;
    step();
    #1;
    total++;
    if (b_wr_ready !== 1'b1 || b_rd_valid !== 1'b0 || b_rd_last !== 1'b0 || b_rd_len !== '0 ||
        b_rd_data_i !== '0 || b_rd_data_q !== '0 || b_bank_full !== 2'b00 || b_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state_b: got rdy=%b v=%b last=%b len=%0d i=%h q=%h full=%b ovf=%b",
               b_wr_ready, b_rd_valid, b_rd_last, b_rd_len, b_rd_data_i, b_rd_data_q, b_bank_full, b_overflow);
    end
    total++;
    if (a_wr_ready !== 1'b1 || a_rd_valid !== 1'b0 || a_bank_full !== 2'b00 || a_overflow !== 1'b0 ||
        a_rd_data_i !== '0 || a_rd_len !== '0) begin
      bad++;
      $display("FAIL reset_state_a: got rdy=%b v=%b full=%b ovf=%b i=%h len=%0d",
               a_wr_ready, a_rd_valid, a_bank_full, a_overflow, a_rd_data_i, a_rd_len);
    end
  endtask

  task automatic test_basic();
    rd_ready = 1'b1;
    write_block(5, 1, 1'b1);
    #1;
    total++;
    if (b_bank_full !== 2'b01 || b_rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_t1: got full=%b v=%b want full=01 v=0", b_bank_full, b_rd_valid);
    end
    step();
    #1;
    total++;
    if (b_rd_valid !== 1'b1 || a_rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_t2: got v a=%b b=%b want 1", a_rd_valid, b_rd_valid);
    end
    drain(1'b0);
    #1;
    total++;
    if (b_bank_full !== 2'b00) begin
      bad++;
      $display("FAIL basic_free: got full=%b want 00", b_bank_full);
    end
  endtask

  task automatic test_back_to_back();
    rd_ready   = 1'b0;
    chk_gap    = 1'b1;
    after_last = 1'b0;
    idle       = 0;
    blocks_out = 0;
    write_block(8, 100, 1'b1);
    write_block(3, 300, 1'b1);
    #1;
    total++;
    if (b_bank_full !== 2'b11 || b_wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL both_full: got full=%b rdy=%b want full=11 rdy=0", b_bank_full, b_wr_ready);
    end
    wr_valid  = 1'b1;
    wr_data_i = pack2(777, 778);
    wr_data_q = pack2(-777, -778);
    step();
    #1;
    total++;
    if (b_wr_ready !== 1'b0 || a_wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_reject: got rdy a=%b b=%b want 0", a_wr_ready, b_wr_ready);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (blocks_out >= 1) break;
      step();
    end
    #1;
    total++;
    if (blocks_out != 1 || b_wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL wr_ready_after_a: got blocks=%0d rdy=%b want 1 and 1", blocks_out, b_wr_ready);
    end
    drain(1'b0);
    chk_gap    = 1'b0;
    after_last = 1'b0;
  endtask

  task automatic test_overflow();
    rd_ready = 1'b1;
    write_block(8, 400, 1'b0);
    drain(1'b0);
    #1;
    total++;
    if (b_overflow !== 1'b1 || a_overflow !== 1'b1) begin
      bad++;
      $display("FAIL overflow_set: got a=%b b=%b want 1", a_overflow, b_overflow);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    total++;
    if (b_overflow !== 1'b1 || b_bank_full !== 2'b00 || b_rd_len !== '0 || b_wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_keep: got ovf=%b full=%b len=%0d rdy=%b want 1 00 0 1",
               b_overflow, b_bank_full, b_rd_len, b_wr_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (b_overflow !== 1'b0 || a_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_clear_ovf: got a=%b b=%b want 0", a_overflow, b_overflow);
    end
  endtask

  task automatic test_backpressure();
    rd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      write_sample(pack2(int'($urandom), int'($urandom)), pack2(int'($urandom), int'($urandom)), k == 5);
    end
    drain(1'b1);
  endtask

  task automatic test_reset_mid();
    rd_ready = 1'b0;
    write_block(6, 500, 1'b1);
    rd_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (sb_b.size() <= 4) break;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++;
    if (b_rd_valid !== 1'b0 || b_bank_full !== 2'b00 || b_wr_ready !== 1'b1 || a_rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b full=%b rdy=%b want 0 00 1", b_rd_valid, b_bank_full, b_wr_ready);
    end
    write_block(2, 600, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_single();
    logic [AW:0] len_one;
    len_one  = 1;
    rd_ready = 1'b1;
    write_sample(pack2(77, -88), pack2(-77, 88), 1'b1);
    step();
    #1;
    total++;
    if (b_rd_valid !== 1'b1 || b_rd_last !== 1'b1 || b_rd_len !== len_one ||
        a_rd_valid !== 1'b1 || a_rd_last !== 1'b1) begin
      bad++;
      $display("FAIL single: got v=%b last=%b len=%0d want 1 1 1", b_rd_valid, b_rd_last, b_rd_len);
    end
    drain(1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    rd_ready   = 1'b0;
    wr_data_i  = '0;
    wr_data_q  = '0;
    last_acc   = 1'b0;
    blocks_out = 0;
    chk_gap    = 1'b0;
    after_last = 1'b0;
    idle       = 0;
    prev_stall = 1'b0;

    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_single();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
